bridge_uart_arbiter: RTL and testbench

Shares one bus-bridge UART link between two bridge requesters (e.g. two slave-port-side transaction sources). It accepts a write or read command from each requester, arbitrates round-robin, serialises the command as one UART TX frame {mode, wdata, addr}, and for reads waits for the UART RX byte. It then returns the data with a one-cycle ack to the requester that issued the command. A timeout reports an error if the remote side never answers.

---
 rtl/bridge_uart_arbiter.sv | 177 +++++++++++++++++
 tb/tb_bridge_uart_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bridge_uart_arbiter.sv
// Two-requester round-robin arbiter in front of a single UART bridge link.
// A granted command is sent as one TX frame {mode, wdata, addr}. Reads then
// wait for one RX byte. Completion is a one-cycle ack to the owning requester.
// Both wait states are bounded by a saturating timeout counter that reports
// err on expiry.
module bridge_uart_arbiter #(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 12,
   parameter int TIMEOUT_CYCLES = 262143
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [1:0]                       req,
   input  logic [1:0]                       req_mode,
   input  logic [2*ADDR_WIDTH-1:0]          req_addr,
   input  logic [2*DATA_WIDTH-1:0]          req_wdata,
   output logic [1:0]                       ack,
   output logic [DATA_WIDTH-1:0]            rdata,
   output logic                             err,
   output logic                             busy,
   output logic [DATA_WIDTH+ADDR_WIDTH:0]   u_din,
   output logic                             u_en,
   input  logic                             u_tx_busy,
   input  logic                             u_rx_ready,
   input  logic [DATA_WIDTH-1:0]            u_dout
);

   localparam int FW = DATA_WIDTH + ADDR_WIDTH + 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

   typedef enum logic [2:0] {IDLE, SEND, BUSYW, TX, RXW, DONE} state_t;

   state_t                  state_q, state_d;
   logic                    id_q, id_d;
   logic                    last_q, last_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [1:0]              ack_q, ack_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    err_q, err_d;
   logic                    busy_q, busy_d;
   logic [FW-1:0]           u_din_q, u_din_d;
   logic                    u_en_q, u_en_d;

   logic                    gnt;
   logic                    mode_g;
   logic [ADDR_WIDTH-1:0]   addr_g;
   logic [DATA_WIDTH-1:0]   wdata_g;
   logic [CW-1:0]           cnt_inc;
   logic                    tmo_hit;
   logic [1:0]              ack_id;

   // Next-state and next-output computation for the arbitration/transfer FSM.
   always_comb begin
      state_d = state_q;
      id_d    = id_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      ack_d   = 2'b00;
      rdata_d = rdata_q;
      err_d   = err_q;
      busy_d  = busy_q;
      u_din_d = u_din_q;
      u_en_d  = 1'b0;

      // Both requesting: serve the one that was not served last time.
      gnt     = (req == 2'b11) ? ~last_q : req[1];
      mode_g  = gnt ? req_mode[1] : req_mode[0];
      addr_g  = gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
      wdata_g = gnt ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
      if (!mode_g) wdata_g = '0;

      // Saturating count; expiry once the count would reach the limit, so the
      // FSM spends exactly TIMEOUT_CYCLES cycles in a wait state.
      cnt_inc = (cnt_q == TMO) ? cnt_q : cnt_q + CW'(1);
      tmo_hit = (cnt_inc == TMO);
      ack_id  = id_q ? 2'b10 : 2'b01;

      case (state_q)
         IDLE: begin
            if (req != 2'b00) begin
               id_d    = gnt;
               last_d  = gnt;
               u_din_d = {mode_g, wdata_g, addr_g};
               err_d   = 1'b0;
               rdata_d = '0;
               u_en_d  = 1'b1;
               busy_d  = 1'b1;
               state_d = SEND;
            end
         end
         SEND: begin
            cnt_d   = '0;
            state_d = BUSYW;
         end
         BUSYW: begin
            if (u_tx_busy) begin
               state_d = TX;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               ack_d   = ack_id;
               state_d = DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         TX: begin
            if (!u_tx_busy) begin
               if (u_din_q[FW-1]) begin
                  ack_d   = ack_id;
                  state_d = DONE;
               end else begin
                  cnt_d   = '0;
                  state_d = RXW;
               end
            end
         end
         RXW: begin
            if (u_rx_ready) begin
               rdata_d = u_dout;
               ack_d   = ack_id;
               state_d = DONE;
            end else if (tmo_hit) begin
               err_d   = 1'b1;
               rdata_d = '0;
               ack_d   = ack_id;
               state_d = DONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         DONE: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // State and registered outputs; pointer resets so requester 0 wins first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         id_q    <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         ack_q   <= 2'b00;
         rdata_q <= '0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         u_din_q <= '0;
         u_en_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         id_q    <= id_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         u_din_q <= u_din_d;
         u_en_q  <= u_en_d;
      end
   end

   assign ack   = ack_q;
   assign rdata = rdata_q;
   assign err   = err_q;
   assign busy  = busy_q;
   assign u_din = u_din_q;
   assign u_en  = u_en_q;

endmodule

// File: tb/tb_bridge_uart_arbiter.sv
// Bench for bridge_uart_arbiter. The reference is a transaction timeline:
// for each grant the bench decides when the UART goes busy, how long it stays
// busy and when (or whether) the RX byte arrives, and from those numbers
// derives the ack cycle, the frame, the granted requester and the result.
module tb_bridge_uart_arbiter;
   localparam int DW = 8;
   localparam int AW = 12;
   localparam int T  = 100;
   localparam int FW = DW + AW + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [1:0]    rq = 2'b00;
   logic [1:0]    rmode = 2'b00;
   logic [2*AW-1:0] raddr = '0;
   logic [2*DW-1:0] rwdata = '0;
   logic [1:0]    ack;
   logic [DW-1:0] rdata;
   logic          err, busy, u_en;
   logic [FW-1:0] u_din;
   logic          u_tx_busy = 1'b0;
   logic          u_rx_ready = 1'b0;
   logic [DW-1:0] u_dout = '0;

   always #5 clk = ~clk;

   bridge_uart_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst(rst), .req(rq), .req_mode(rmode), .req_addr(raddr),
      .req_wdata(rwdata), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
      .u_din(u_din), .u_en(u_en), .u_tx_busy(u_tx_busy),
      .u_rx_ready(u_rx_ready), .u_dout(u_dout));

   int checks = 0, failures = 0, cyc = 0, nacks = 0;

   // transaction model
   bit            act;
   int            e_cyc, ack_cyc, rr_last, aid;
   bit            amode;
   logic [FW-1:0] frame_m;
   logic [DW-1:0] exp_rdata;
   logic          exp_err;
   int            pd, pl, pk;        // busy delay after u_en (-1 never), busy length, RX offset in RXW (-1 never)
   logic [DW-1:0] pbyte;
   bit            hold[2];
   int            policy;            // 0 manual, 1 refill writes on ack, 2 random traffic
   bit            stray_en, rand_plan;

   // what the DUT did
   int            uen_seen, ack_seen;
   logic [FW-1:0] din_seen;
   logic [1:0]    ackid_seen;
   logic [DW-1:0] rd_seen;
   logic          err_seen;
   int            gq[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic raise(input int i, input bit m, input logic [AW-1:0] a, input logic [DW-1:0] d);
      rq[i] = 1'b1;
      rmode[i] = m;
      raddr[i*AW +: AW] = a;
      rwdata[i*DW +: DW] = d;
      hold[i] = 1'b1;
   endtask

   // Checks the current cycle against the timeline, then acts as the requesters.
   task automatic observe();
      logic [1:0] exp_ack;
      bit exp_uen;
      exp_uen = 1'b0;
      if (act && cyc - 1 == ack_cyc) begin
         act = 1'b0;
      end else if (!act && rq != 2'b00) begin
         exp_uen = 1'b1;
         if (rq == 2'b11) aid = (rr_last == 0) ? 1 : 0;
         else aid = rq[1] ? 1 : 0;
         rr_last = aid;
         amode = rmode[aid];
         frame_m = {amode, amode ? rwdata[aid*DW +: DW] : {DW{1'b0}}, raddr[aid*AW +: AW]};
         act = 1'b1;
         e_cyc = cyc;
         if (rand_plan) begin
            pd = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 3));
            pl = int'($urandom_range(1, 6));
            pk = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 4));
            pbyte = DW'($urandom);
         end
         exp_err = 1'b0;
         exp_rdata = '0;
         if (pd < 0) begin
            ack_cyc = e_cyc + 1 + T; exp_err = 1'b1;
         end else if (amode) begin
            ack_cyc = e_cyc + pd + pl + 2;
         end else if (pk >= 0 && pk < T) begin
            ack_cyc = e_cyc + pd + pl + 2 + pk + 1; exp_rdata = pbyte;
         end else begin
            ack_cyc = e_cyc + pd + pl + 2 + T; exp_err = 1'b1;
         end
      end
      exp_ack = (act && cyc == ack_cyc) ? ((aid == 1) ? 2'b10 : 2'b01) : 2'b00;
      chk("u_en", 32'(u_en), 32'(exp_uen));
      chk("busy", 32'(busy), 32'(act));
      chk("u_din", 32'(u_din), 32'(frame_m));
      chk("ack", 32'(ack), 32'(exp_ack));
      if (exp_ack != 2'b00) begin
         chk("rdata", 32'(rdata), 32'(exp_rdata));
         chk("err", 32'(err), 32'(exp_err));
      end
      if (u_en) begin uen_seen = cyc; din_seen = u_din; end
      if (ack != 2'b00) begin
         ack_seen = cyc; ackid_seen = ack; rd_seen = rdata; err_seen = err;
         gq.push_back(ack[1] ? 1 : 0);
         nacks++;
      end
      if (exp_ack != 2'b00) begin
         hold[aid] = 1'b0;
         rq[aid] = 1'b0;
         if (policy == 1) raise(aid, 1'b1, AW'($urandom), DW'($urandom));
      end
      if (policy == 2) begin
         if (exp_uen && $urandom_range(0, 1) == 1) begin
            rmode[aid] = ~rmode[aid];
            raddr[aid*AW +: AW] = AW'($urandom);
            rwdata[aid*DW +: DW] = DW'($urandom);
            if ($urandom_range(0, 3) == 0) rq[aid] = 1'b0;
         end
         for (int i = 0; i < 2; i++)
            if (!hold[i] && $urandom_range(0, 3) == 0)
               raise(i, ($urandom_range(0, 1) == 1), AW'($urandom), DW'($urandom));
      end
   endtask

   // UART behaviour for the current cycle, taken from the transaction plan.
   task automatic drive_uart();
      int r;
      bit in_rxw;
      in_rxw = 1'b0;
      u_tx_busy = 1'b0;
      u_rx_ready = 1'b0;
      u_dout = DW'($urandom);
      if (act && pd >= 0) begin
         r = e_cyc + pd + pl + 2;
         u_tx_busy = (cyc >= e_cyc + 1 + pd) && (cyc <= e_cyc + pd + pl);
         in_rxw = !amode && cyc >= r && cyc < ack_cyc;
         if (in_rxw && pk >= 0 && cyc == r + pk) begin
            u_rx_ready = 1'b1;
            u_dout = pbyte;
         end
      end
      if (!in_rxw && stray_en && (cyc % 2 == 0)) u_rx_ready = 1'b1;
   endtask

   task automatic step();
      drive_uart();
      @(posedge clk);
      cyc++;
      #1;
      observe();
   endtask

   task automatic run_until(input int n, input int budget);
      int start, k;
      start = nacks;
      k = 0;
      while (nacks - start < n && k < budget) begin
         step();
         k++;
      end
      chk("ack_count_in_bound", 32'(nacks - start), 32'(n));
   endtask

   task automatic reset_model();
      act = 1'b0; rr_last = 1; frame_m = '0;
      hold[0] = 1'b0; hold[1] = 1'b0; rq = 2'b00;
   endtask

   initial begin
      reset_model();
      pd = 0; pl = 1; pk = 0; pbyte = '0;
      policy = 0; stray_en = 1'b0; rand_plan = 1'b0;
      e_cyc = 0; ack_cyc = 0; aid = 0; amode = 1'b0;
      exp_rdata = '0; exp_err = 1'b0;
      uen_seen = 0; ack_seen = 0; din_seen = '0; ackid_seen = '0; rd_seen = '0; err_seen = 1'b0;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ack", 32'(ack), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_u_en", 32'(u_en), 0);
      chk("rst_u_din", 32'(u_din), 0);
      chk("rst_rdata", 32'(rdata), 0);
      chk("rst_err", 32'(err), 0);
      rst = 1'b0;
      observe();

      // write from requester 0, 20-cycle UART busy starting the cycle after u_en
      pd = 0; pl = 20; pk = 0;
      raise(0, 1'b1, 12'h123, 8'hA5);
      run_until(1, 200);
      chk("wr_frame", 32'(din_seen), 32'h1A5123);
      chk("wr_ackid", 32'(ackid_seen), 32'h1);
      chk("wr_latency", 32'(ack_seen - uen_seen), 22);
      chk("wr_err", 32'(err_seen), 0);
      chk("wr_rdata", 32'(rd_seen), 0);
      repeat (3) step();

      // read from requester 1 with stray RX pulses before RXW
      stray_en = 1'b1;
      pd = 1; pl = 5; pk = 3; pbyte = 8'h3C;
      raise(1, 1'b0, 12'h0F0, 8'hEE);
      run_until(1, 200);
      stray_en = 1'b0;
      chk("rd_frame", 32'(din_seen), 32'h0000F0);
      chk("rd_ackid", 32'(ackid_seen), 32'h2);
      chk("rd_rdata", 32'(rd_seen), 32'h3C);
      chk("rd_err", 32'(err_seen), 0);
      chk("rd_latency", 32'(ack_seen - uen_seen), 12);
      repeat (3) step();

      // both requesters held with writes: grants alternate starting at 0
      gq.delete();
      policy = 1; pd = 0; pl = 3;
      raise(0, 1'b1, 12'h111, 8'h11);
      raise(1, 1'b1, 12'h222, 8'h22);
      run_until(4, 400);
      policy = 0;
      reset_model_reqs();
      chk("rr_count", 32'(gq.size()), 4);
      if (gq.size() >= 4)
         for (int i = 0; i < 4; i++) chk($sformatf("rr_grant%0d", i), 32'(gq[i]), 32'(i % 2));
      repeat (3) step();

      // read with no RX answer: timeout after T cycles in RXW
      pd = 0; pl = 2; pk = -1;
      raise(0, 1'b0, 12'h055, 8'h00);
      run_until(1, 300);
      chk("rxto_latency", 32'(ack_seen - uen_seen - 4), 32'(T));
      chk("rxto_err", 32'(err_seen), 1);
      chk("rxto_rdata", 32'(rd_seen), 0);
      begin
         int n0;
         n0 = nacks;
         stray_en = 1'b1;
         repeat (10) step();
         stray_en = 1'b0;
         chk("late_rx_no_ack", 32'(nacks - n0), 0);
      end

      // UART never goes busy: timeout in BUSYW, then a normal write
      pd = -1;
      raise(1, 1'b1, 12'hABC, 8'h5A);
      run_until(1, 300);
      chk("bwto_latency", 32'(ack_seen - uen_seen), 32'(T + 1));
      chk("bwto_err", 32'(err_seen), 1);
      chk("bwto_ackid", 32'(ackid_seen), 32'h2);
      pd = 0; pl = 4;
      raise(0, 1'b1, 12'h321, 8'h77);
      run_until(1, 100);
      chk("after_to_err", 32'(err_seen), 0);
      chk("after_to_ackid", 32'(ackid_seen), 32'h1);

      // asynchronous reset while in TX
      pd = 0; pl = 20;
      raise(0, 1'b1, 12'h456, 8'h12);
      repeat (6) step();
      rst = 1'b1;
      u_tx_busy = 1'b0; u_rx_ready = 1'b0;
      #1;
      chk("arst_u_en", 32'(u_en), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ack", 32'(ack), 0);
      chk("arst_u_din", 32'(u_din), 0);
      @(posedge clk);
      cyc++;
      #1;
      chk("arst_edge_busy", 32'(busy), 0);
      chk("arst_edge_u_din", 32'(u_din), 0);
      rst = 1'b0;
      reset_model();
      observe();
      gq.delete();
      pl = 2;
      raise(0, 1'b1, 12'h0A0, 8'h01);
      raise(1, 1'b1, 12'h0B0, 8'h02);
      run_until(2, 100);
      chk("arst_grant_count", 32'(gq.size()), 2);
      if (gq.size() >= 2) begin
         chk("arst_first_grant", 32'(gq[0]), 0);
         chk("arst_second_grant", 32'(gq[1]), 1);
      end

      // random traffic, random UART timing, stray RX bytes, field changes after grant
      policy = 2; rand_plan = 1'b1; stray_en = 1'b1;
      run_until(40, 8000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   task automatic reset_model_reqs();
      rq = 2'b00;
      hold[0] = 1'b0;
      hold[1] = 1'b0;
   endtask

endmodule
